// File: rtl/regfile_wb_arbiter.sv
// Two-port writeback arbiter sharing one register-file write port; writes to ZERO_REG are absorbed.
// Optional REGFILE_WB_ARB_RR_EN: round-robin arbitration when both holds are valid (default: port 1 wins).
module regfile_wb_arbiter #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic [ADDR_W-1:0] wa3,
  output logic [DATA_W-1:0] wd3,
  output logic              we3,
  output logic              busy,
  output logic [7:0]        drop_cnt
);

  logic              hold0_v, hold1_v;
  logic [ADDR_W-1:0] hold0_addr, hold1_addr;
  logic [DATA_W-1:0] hold0_data, hold1_data;
  logic              grant0, grant1;
  logic              accept0, accept1;
  logic              drop0, drop1;
  logic [1:0]        drop_inc;
  logic [8:0]        drop_sum;

`ifdef REGFILE_WB_ARB_RR_EN
  typedef enum logic {PORT0 = 1'b0, PORT1 = 1'b1} rr_e;
  rr_e rr_ptr;

  always_comb begin
    grant0 = hold0_v & (~hold1_v | (rr_ptr == PORT0));
    grant1 = hold1_v & (~hold0_v | (rr_ptr == PORT1));
  end

  // Pointer only moves on contested grants.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      rr_ptr <= PORT1;
    else if (hold0_v && hold1_v)
      rr_ptr <= (rr_ptr == PORT1) ? PORT0 : PORT1;
  end
`else
  always_comb begin
    grant1 = hold1_v;
    grant0 = hold0_v & ~hold1_v;
  end
`endif

  always_comb begin
    req0_ready = ~hold0_v | grant0;
    req1_ready = ~hold1_v | grant1;
    accept0    = req0_valid & req0_ready;
    accept1    = req1_valid & req1_ready;
    drop0      = accept0 & (req0_addr == ADDR_W'(ZERO_REG));
    drop1      = accept1 & (req1_addr == ADDR_W'(ZERO_REG));
    drop_inc   = {1'b0, drop0} + {1'b0, drop1};
    drop_sum   = {1'b0, drop_cnt} + {7'd0, drop_inc};
    busy       = hold0_v | hold1_v | we3;
  end

  // A new accept takes priority over the invalidate from a same-cycle grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold0_v    <= 1'b0;
      hold0_addr <= '0;
      hold0_data <= '0;
    end else if (accept0 && !drop0) begin
      hold0_v    <= 1'b1;
      hold0_addr <= req0_addr;
      hold0_data <= req0_data;
    end else if (grant0) begin
      hold0_v    <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold1_v    <= 1'b0;
      hold1_addr <= '0;
      hold1_data <= '0;
    end else if (accept1 && !drop1) begin
      hold1_v    <= 1'b1;
      hold1_addr <= req1_addr;
      hold1_data <= req1_data;
    end else if (grant1) begin
      hold1_v    <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we3 <= 1'b0;
      wa3 <= '0;
      wd3 <= '0;
    end else begin
      we3 <= grant0 | grant1;
      if (grant1) begin
        wa3 <= hold1_addr;
        wd3 <= hold1_data;
      end else if (grant0) begin
        wa3 <= hold0_addr;
        wd3 <= hold0_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      drop_cnt <= '0;
    else
      drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: expected writes queued by stimulus, checked by a we3 monitor.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [4:0]  req0_addr = '0, req1_addr = '0;
  logic [63:0] req0_data = '0, req1_data = '0;
  logic        req0_ready, req1_ready;
  logic [4:0]  wa3;
  logic [63:0] wd3;
  logic        we3, busy;
  logic [7:0]  drop_cnt;

  typedef struct packed {
    logic [4:0]  a;
    logic [63:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  cyc = 0;
  int  wr_cnt = 0;
  int  first_wr = -1;
  int  last_wr = -1;

  regfile_wb_arbiter #(.DATA_W(64), .ADDR_W(5), .ZERO_REG(31)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .wa3(wa3), .wd3(wd3), .we3(we3), .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && we3) begin
      wr_cnt++;
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got wa3=%0d wd3=0x%0h, expected no write", wa3, wd3);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", {59'd0, wa3}, {59'd0, e.a});
        check("write_data", wd3, e.d);
      end
    end
  end

  task automatic send0(input logic [4:0] a, input logic [63:0] d);
    bit acc;
    int n;
    n = 0;
    req0_valid = 1'b1; req0_addr = a; req0_data = d;
    do begin
      acc = req0_ready;
      @(negedge clk);
      n++;
    end while (!acc && n < 100);
    if (!acc) check("send0_timeout", 64'd0, 64'd1);
    req0_valid = 1'b0;
  endtask

  task automatic send1(input logic [4:0] a, input logic [63:0] d);
    bit acc;
    int n;
    n = 0;
    req1_valid = 1'b1; req1_addr = a; req1_data = d;
    do begin
      acc = req1_ready;
      @(negedge clk);
      n++;
    end while (!acc && n < 100);
    if (!acc) check("send1_timeout", 64'd0, 64'd1);
    req1_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  function automatic wr_t mk(input logic [4:0] a, input logic [63:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    return w;
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    #1 reset = 1'b1;
    #1;
    check("reset_we3", {63'd0, we3}, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_drop_cnt", {56'd0, drop_cnt}, 64'd0);
    check("reset_wa3", {59'd0, wa3}, 64'd0);
    check("reset_wd3", wd3, 64'd0);
    check("reset_ready0", {63'd0, req0_ready}, 64'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Single write: accepted edge 0, we3 during cycle 2 only, idle in cycle 3.
    exp_q.push_back(mk(5'd5, 64'hDEAD));
    send0(5'd5, 64'hDEAD);
    check("single_busy_c1", {63'd0, busy}, 64'd1);
    @(negedge clk);
    check("single_we3_c2", {63'd0, we3}, 64'd1);
    @(negedge clk);
    check("single_we3_c3", {63'd0, we3}, 64'd0);
    check("single_busy_c3", {63'd0, busy}, 64'd0);
    drain();

    // Contention: port 1 written first, port 0 held not-ready meanwhile.
    exp_q.push_back(mk(5'd4, 64'h4));
    exp_q.push_back(mk(5'd3, 64'h3));
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 64'h3;
    req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 64'h4;
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("contend_ready0_low", {63'd0, req0_ready}, 64'd0);
    check("contend_ready1_high", {63'd0, req1_ready}, 64'd1);
    drain();

    // XZR drops: single, dual same-cycle, then saturation.
    send0(5'd31, 64'h77);
    check("xzr_drop_1", {56'd0, drop_cnt}, 64'd1);
    check("xzr_busy", {63'd0, busy}, 64'd0);
    req0_valid = 1'b1; req0_addr = 5'd31; req0_data = 64'h1;
    req1_valid = 1'b1; req1_addr = 5'd31; req1_data = 64'h2;
    @(negedge clk);
    check("xzr_drop_dual", {56'd0, drop_cnt}, 64'd3);
    repeat (150) @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("xzr_drop_saturate", {56'd0, drop_cnt}, 64'd255);
    repeat (3) @(negedge clk);

    // Asynchronous reset while both holds are valid.
    wr_cnt = 0;
    req0_valid = 1'b1; req0_addr = 5'd9;  req0_data = 64'h9;
    req1_valid = 1'b1; req1_addr = 5'd10; req1_data = 64'h10;
    @(posedge clk);
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("rst_pre_busy", {63'd0, busy}, 64'd1);
    #1 reset = 1'b1;
    #1;
    check("rst_async_we3", {63'd0, we3}, 64'd0);
    check("rst_async_busy", {63'd0, busy}, 64'd0);
    check("rst_async_drop", {56'd0, drop_cnt}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_no_replay", 64'(wr_cnt), 64'd0);
    check("rst_idle_busy", {63'd0, busy}, 64'd0);

    // Same address on both ports: port 1 first (pointer fresh from reset), port 0 data final.
    exp_q.push_back(mk(5'd7, 64'hB));
    exp_q.push_back(mk(5'd7, 64'hA));
    req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 64'hA;
    req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 64'hB;
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain();
    check("same_addr_final_wd3", wd3, 64'hA);

    // Streaming: 4 beats per port, 8 writes on consecutive cycles.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    wr_cnt = 0; first_wr = -1; last_wr = -1;
`ifdef REGFILE_WB_ARB_RR_EN
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(mk(5'(20 + i), 64'(32'h200 + i)));
      exp_q.push_back(mk(5'(10 + i), 64'(32'h100 + i)));
    end
`else
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(5'(20 + i), 64'(32'h200 + i)));
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(5'(10 + i), 64'(32'h100 + i)));
`endif
    fork
      begin
        for (int i = 0; i < 4; i++) send0(5'(10 + i), 64'(32'h100 + i));
      end
      begin
        for (int j = 0; j < 4; j++) send1(5'(20 + j), 64'(32'h200 + j));
      end
    join
    drain();
    check("stream_write_count", 64'(wr_cnt), 64'd8);
    check("stream_consecutive", 64'(last_wr - first_wr), 64'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
